// File: rtl/gpu_ci_issue.sv
// rtl/gpu_ci_issue.sv - CPU-side issuer for GPU custom instructions
// Drives the CI command/response handshake and returns the result to core writeback.
module gpu_ci_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] TIMEOUT_CODE   = 64'hDEAD_DEAD_DEAD_0002,
  parameter logic [63:0] STUB_CODE      = 64'hDEAD_DEAD_DEAD_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [7:0]  issue_op,
  input  logic [63:0] issue_rs1,
  input  logic [63:0] issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_err,
  output logic        busy,
  output logic        ci_valid,
  output logic [7:0]  ci_op,
  output logic [63:0] ci_arg0,
  output logic [63:0] ci_arg1,
  input  logic        ci_ready,
  input  logic        ci_rsp_valid,
  input  logic [63:0] ci_rsp_data,
  output logic        ci_rsp_ready,
  output logic        stale_rsp
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0]    op_q;
  logic [63:0]   arg0_q, arg1_q;
  logic [4:0]    rd_q;
  logic [63:0]   data_q;
  logic          err_q;
  logic          stale_q;
  logic          timeout;

  // The watchdog spans both REQ and RSP so a stuck responder can never hang the core.
  assign timeout = ((state == S_REQ) || (state == S_RSP)) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    issue_ready  = 1'b0;
    ci_valid     = 1'b0;
    wb_valid     = 1'b0;
    ci_rsp_ready = 1'b1;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        issue_ready = 1'b1;
        busy        = 1'b0;
        if (issue_valid) state_n = S_REQ;
      end
      S_REQ: begin
        ci_valid     = 1'b1;
        ci_rsp_ready = 1'b0;
        if (timeout)       state_n = S_WB;
        else if (ci_ready) state_n = S_RSP;
      end
      S_RSP: begin
        // A response arriving on the timeout cycle still wins.
        if (ci_rsp_valid || timeout) state_n = S_WB;
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      stale_q <= ci_rsp_valid && (state != S_RSP);
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            op_q   <= issue_op;
            arg0_q <= issue_rs1;
            arg1_q <= issue_rs2;
            rd_q   <= issue_rd;
            cnt    <= '0;
          end
        end
        S_REQ: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (timeout) begin
            data_q <= TIMEOUT_CODE;
            err_q  <= 1'b1;
          end
        end
        S_RSP: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (ci_rsp_valid) begin
            data_q <= ci_rsp_data;
            err_q  <= (ci_rsp_data == STUB_CODE);
          end else if (timeout) begin
            data_q <= TIMEOUT_CODE;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ci_op     = op_q;
  assign ci_arg0   = arg0_q;
  assign ci_arg1   = arg1_q;
  assign wb_rd     = rd_q;
  assign wb_data   = data_q;
  assign wb_err    = err_q;
  assign stale_rsp = stale_q;

endmodule

// File: doc/gpu_ci_issue.md
Name: gpu_ci_issue

Overview:
CPU-side issuer for GPU custom instructions; it sits directly upstream of the GPU CI responder (real GPU or unconnected-core stub).
- Accepts one decoded CUSTOM-0 instruction from the core, drives the CI command handshake and collects the CI response.
- Returns the result to the core's writeback port with an error flag.
- A watchdog timeout guarantees the core's S_GPU state always terminates.

Parameters:
TIMEOUT_CYCLES, 1024, cycles allowed from entering REQ until response capture; legal range ≥ 2.
TIMEOUT_CODE, 64'hDEAD_DEAD_DEAD_0002, wb_data returned on timeout.
STUB_CODE, 64'hDEAD_DEAD_DEAD_0001, response value that marks "GPU CI not connected".

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  core presents custom instruction
issue_ready  out  1  issuer idle, can accept
issue_op  in  8  CI opcode
issue_rs1  in  64  operand 0
issue_rs2  in  64  operand 1
issue_rd  in  5  destination register
wb_valid  out  1  result available
wb_ready  in  1  core consumes result
wb_rd  out  5  destination register of result
wb_data  out  64  result data
wb_err  out  1  result is stub code or timeout
busy  out  1  high in any state except IDLE
ci_valid  out  1  command valid to responder
ci_op  out  8  latched opcode
ci_arg0  out  64  latched rs1
ci_arg1  out  64  latched rs2
ci_ready  in  1  responder accepts command
ci_rsp_valid  in  1  responder result valid
ci_rsp_data  in  64  responder result
ci_rsp_ready  out  1  issuer accepts response
stale_rsp  out  1  one-cycle pulse: response discarded

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - All outputs 0 except issue_ready = 1 and ci_rsp_ready = 1.
  - Latched op, args, rd and data registers = 0; timeout counter = 0.
- Reset mid-operation aborts the command with no wb_valid produced.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- FSM states: IDLE, REQ, RSP, WB.
- IDLE:
  - issue_ready = 1, ci_rsp_ready = 1.
  - On issue_valid, latch op, rs1, rs2 and rd, clear the counter, and go to REQ.
- REQ:
  - ci_valid = 1; ci_op, ci_arg0 and ci_arg1 stay stable until handshake.
  - On ci_valid && ci_ready, go to RSP; ci_valid is 0 from the next cycle, so ci_valid is high for exactly one cycle when ci_ready = 1.
  - Counter increments every cycle.
- RSP:
  - ci_rsp_ready = 1; counter keeps incrementing.
  - On ci_rsp_valid, capture wb_data = ci_rsp_data and set wb_err = (ci_rsp_data == STUB_CODE); go to WB.
- Timeout:
  - Applies in REQ or RSP. If the counter reaches TIMEOUT_CYCLES-1 without a response capture, go to WB with wb_data = TIMEOUT_CODE and wb_err = 1.
  - If the response and timeout coincide in RSP, the response wins.
  - Counter width is clog2(TIMEOUT_CYCLES+1); the counter does not wrap.
- WB:
  - wb_valid = 1 with wb_rd, wb_data and wb_err stable until wb_ready; then go to IDLE.
  - issue_ready = 0, ci_rsp_ready = 1.
- Stale responses:
  - A ci_rsp_valid seen in IDLE, REQ or WB is discarded: stale_rsp pulses 1 for one cycle and registers are unchanged.
  - Stale responses are a known limitation after a timeout.
- wb_valid and ci_valid are never high in the same cycle.
- busy = (state != IDLE).
- Latency with an always-ready responder that answers one cycle after ci_valid: wb_valid is high on the 3rd clock edge after the issue handshake edge.

Test Plan:
1. Responder with ci_ready = 1 returning rsp 64'h0000_0000_0000_1234 one cycle after ci_valid; issue op = 8'h05, rd = 7, wb_ready = 1 -> ci_valid high exactly 1 cycle with ci_op = 8'h05; wb_valid 3 edges after accept; wb_rd = 7, wb_data = 64'h1234, wb_err = 0; back to IDLE.
2. Stub-style responder returning 64'hDEAD_DEAD_DEAD_0001 -> wb_data = 64'hDEAD_DEAD_DEAD_0001, wb_err = 1, no deadlock.
3. ci_ready held 0 for 5 cycles, then 1 -> ci_op, ci_arg0 and ci_arg1 stable throughout; single handshake; correct result.
4. TIMEOUT_CYCLES = 16 and the responder never answers -> wb_valid with wb_data = 64'hDEAD_DEAD_DEAD_0002, wb_err = 1, 16 cycles after entering REQ. A later ci_rsp_valid in IDLE -> stale_rsp 1-cycle pulse, no wb_valid.
5. wb_ready held 0 for 4 cycles -> wb_valid and wb_data stable; issue_ready = 0; new issue_valid ignored until wb_ready handshake completes.
6. rst_n asserted low while in RSP -> all outputs return to their reset values immediately; after release, issue_ready = 1 and a new command completes normally.
